// File: rtl/riscv_lsu_if.sv
// Execute-to-LSU request/response signals plus the LSU data-memory bus, bundled as one port.
// Latency: none, wiring only.
// Backpressure: request side uses valid/ready; bus side holds req until ack, err or timeout.
interface riscv_lsu_if #(
    parameter int XLEN = 32
);
    // Execute-stage request and writeback response
    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic            i_lsu_we;
    logic [2:0]      i_lsu_funct3;
    logic [XLEN-1:0] i_lsu_addr;
    logic [XLEN-1:0] i_lsu_wdata;
    logic [XLEN-1:0] o_lsu_rdata;
    logic            o_lsu_done;
    logic            o_lsu_err;
    logic            o_lsu_misalign;

    // Data-memory bus
    logic            o_dmem_req;
    logic            o_dmem_we;
    logic [XLEN-1:0] o_dmem_addr;
    logic [XLEN-1:0] o_dmem_wdata;
    logic [3:0]      o_dmem_be;
    logic            i_dmem_ack;
    logic [XLEN-1:0] i_dmem_rdata;
    logic            i_dmem_err;

    // Core pipeline and memory model side
    modport master (
        output i_lsu_valid, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
        input  o_lsu_ready, o_lsu_rdata, o_lsu_done, o_lsu_err, o_lsu_misalign,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        output i_dmem_ack, i_dmem_rdata, i_dmem_err
    );

    // Load/store unit side
    modport slave (
        input  i_lsu_valid, i_lsu_we, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
        output o_lsu_ready, o_lsu_rdata, o_lsu_done, o_lsu_err, o_lsu_misalign,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        input  i_dmem_ack, i_dmem_rdata, i_dmem_err
    );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one req/ack bus access per op, byte enables, load extension, timeout. Optional macro LSU_MISALIGN_TRAP_EN.
// Latency: accept at edge 0, req from cycle 1, ack at edge N gives done in cycle N+1 (min 2 cycles; issue every 3).
// Backpressure: ready only in IDLE; bus req held until ack, err or BUS_TIMEOUT BUSY cycles.
module riscv_lsu #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    riscv_lsu_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  tmo_cnt;
    logic        ready_q, done_q, err_q, req_q, dmem_we_q;
    logic [31:0] rdata_q, dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_be_q;

    // Request-side decode: access size from funct3[1:0]; 011/110/111 fall into the word case
    logic        is_byte, is_half;
    logic [1:0]  off_al;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    assign is_byte = (bus.i_lsu_funct3[1:0] == 2'b00);
    assign is_half = (bus.i_lsu_funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misal;
    logic misal_q;
    assign req_misal = (is_half && bus.i_lsu_addr[0]) ||
                       (!is_byte && !is_half && (bus.i_lsu_addr[1:0] != 2'b00));
`endif

    // Force natural alignment of the lane offset, then build byte enables and replicated store data
    always_comb begin
        off_al  = bus.i_lsu_addr[1:0];
        be_n    = 4'b1111;
        wdata_n = bus.i_lsu_wdata;
        if (is_half) begin
            off_al[0] = 1'b0;
        end else if (!is_byte) begin
            off_al = 2'b00;
        end
        if (bus.i_lsu_we) begin
            if (is_byte) begin
                be_n    = 4'b0001 << off_al;
                wdata_n = {4{bus.i_lsu_wdata[7:0]}};
            end else if (is_half) begin
                be_n    = off_al[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{bus.i_lsu_wdata[15:0]}};
            end
        end
    end

    // Load lane selection and sign/zero extension from the latched offset and funct3
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.i_dmem_rdata[7:0];
            2'd1:    ld_byte = bus.i_dmem_rdata[15:8];
            2'd2:    ld_byte = bus.i_dmem_rdata[23:16];
            default: ld_byte = bus.i_dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_ext = bus.i_dmem_rdata;
        endcase
    end

    logic tmo_hit;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Control FSM plus all registered outputs; reset drops req asynchronously
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            tmo_cnt      <= 8'd0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            req_q        <= 1'b0;
            dmem_we_q    <= 1'b0;
            rdata_q      <= 32'd0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_be_q    <= 4'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_lsu_valid) begin
                        we_q         <= bus.i_lsu_we;
                        funct3_q     <= bus.i_lsu_funct3;
                        off_q        <= off_al;
                        dmem_addr_q  <= {bus.i_lsu_addr[31:2], 2'b00};
                        dmem_be_q    <= be_n;
                        dmem_wdata_q <= wdata_n;
                        dmem_we_q    <= bus.i_lsu_we;
                        tmo_cnt      <= 8'd0;
                        ready_q      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (req_misal) begin
                            state   <= S_RESP;
                            done_q  <= 1'b1;
                            misal_q <= 1'b1;
                        end else
`endif
                        begin
                            state <= S_BUSY;
                            req_q <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.i_dmem_err || bus.i_dmem_ack || tmo_hit) begin
                        state  <= S_RESP;
                        req_q  <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= bus.i_dmem_err || !bus.i_dmem_ack;
                        if (!we_q) begin
                            rdata_q <= (bus.i_dmem_ack && !bus.i_dmem_err) ? ld_ext : 32'd0;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misal_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.o_lsu_ready  = ready_q;
    assign bus.o_lsu_done   = done_q;
    assign bus.o_lsu_err    = err_q;
    assign bus.o_lsu_rdata  = rdata_q;
    assign bus.o_dmem_req   = req_q;
    assign bus.o_dmem_we    = dmem_we_q;
    assign bus.o_dmem_addr  = dmem_addr_q;
    assign bus.o_dmem_wdata = dmem_wdata_q;
    assign bus.o_dmem_be    = dmem_be_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.o_lsu_misalign = misal_q;
`else
    assign bus.o_lsu_misalign = 1'b0;
`endif
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the RV32I core's memory stage. It takes the effective address produced by the execute-stage ALU (`o_alu_result`), the store data (rs2) and funct3. It then runs one data-memory bus transaction with a req/ack handshake and returns aligned, sign- or zero-extended load data to writeback. The unit also generates byte enables, checks alignment and enforces a bus timeout.

## Interface
- `BUS_TIMEOUT`, default 255: number of cycles in BUSY without ack/err before the access is aborted with error; valid range 1..255.
- `i_clk` in 1: clock, rising edge.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_lsu_valid` in 1: memory operation request from execute.
- `o_lsu_ready` out 1: LSU idle and accepting; a request is accepted when `i_lsu_valid && o_lsu_ready`.
- `i_lsu_we` in 1: 1 = store, 0 = load.
- `i_lsu_funct3` in 3: RV32I load/store funct3.
- `i_lsu_addr` in `XLEN`: effective address (ALU result).
- `i_lsu_wdata` in `XLEN`: store data (rs2).
- `o_lsu_rdata` out `XLEN`: extended load data.
- `o_lsu_done` out 1: one-cycle completion pulse.
- `o_lsu_err` out 1: bus error or timeout; valid with `o_lsu_done`.
- `o_lsu_misalign` out 1: misaligned access; valid with `o_lsu_done`.
- `o_dmem_req` out 1: bus request, held until ack, err or timeout.
- `o_dmem_we` out 1: bus write.
- `o_dmem_addr` out `XLEN`: word address, bits [1:0] = 0.
- `o_dmem_wdata` out `XLEN`: lane-replicated store data.
- `o_dmem_be` out 4: byte enables; all-ones for loads.
- `i_dmem_ack` in 1: transfer complete.
- `i_dmem_rdata` in `XLEN`: read word, valid with ack.
- `i_dmem_err` in 1: bus error.

## Operation
- FSM has three states.
  - IDLE → BUSY on accept.
  - IDLE → RESP on accept of a misaligned access (macro enabled).
  - BUSY → RESP on ack, err or timeout.
  - RESP → IDLE unconditionally.
- `o_lsu_ready` = 1 only in IDLE; `o_lsu_done` = 1 only in RESP.
- On accept the unit latches `we`, `funct3`, `addr[1:0]`, `o_dmem_addr = {addr[31:2],2'b00}`, `be` and `wdata`; the inputs are don't-care afterwards.
- Stores:
  - SB (000): `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH (001): `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{wdata[15:0]}}`.
  - SW (010): `be = 4'b1111`.
- Loads select the lane by latched `addr[1:0]`.
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word through.
- Undefined funct3 values (011, 110, 111) are treated as word access.
- `o_lsu_rdata` is updated only in the BUSY→RESP transition of a load.
  - It takes the extended data on ack, or 0 on err/timeout.
  - It is held otherwise; stores leave it unchanged.
- Misaligned access: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
- Timeout counter:
  - Cleared on accept; increments each BUSY cycle.
  - When it reaches `BUS_TIMEOUT` with no ack/err, the FSM goes BUSY→RESP with `o_lsu_err` = 1.
- Simultaneous events:
  - `i_dmem_err` and `i_dmem_ack` in the same cycle: err wins.
  - Ack in the timeout cycle: ack wins (no error).
- ack/err seen in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE, `o_lsu_ready` 1, every other output 0, timeout counter 0.
- Reset asserted mid-transaction drops `o_dmem_req` immediately (asynchronously); no done is generated.
- All outputs are registered; no combinational path from `i_dmem_*` to `o_dmem_*`.
- Latency:
  - Accept at edge 0.
  - `o_dmem_req` high from cycle 1.
  - Ack sampled at edge N (earliest N = 1) gives `o_lsu_done` in cycle N+1.
  - Minimum accept-to-done is 2 cycles; minimum back-to-back issue is every 3 cycles.
- `o_dmem_req`, `o_dmem_addr`, `o_dmem_we`, `o_dmem_be` and `o_dmem_wdata` are stable for every cycle req is high.
- Req deasserts in the cycle after ack/err/timeout.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access goes IDLE→RESP with `o_lsu_misalign` = 1 and `o_lsu_done` = 1.
  - No bus request is issued; `o_lsu_rdata` is unchanged.
- Undefined:
  - `o_lsu_misalign` is tied 0.
  - Address low bits are forced to natural alignment (`addr[0]` cleared for halfword, `addr[1:0]` cleared for word) and the access proceeds normally.

## Test plan
- LW at addr 0x100, ack one cycle after req with rdata 0xDEADBEEF → `o_dmem_addr` 0x100, `be` 4'b1111, `o_lsu_done` in cycle 2, `o_lsu_rdata` 0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF7F01 → rdata 0xFFFFFF80 for LB, 0x00000080 for LBU; LH at 0x102 → 0xFFFF80FF.
- SB at 0x201 with wdata 0x000000A5 → `o_dmem_addr` 0x200, `be` 4'b0010, `o_dmem_wdata` 0xA5A5A5A5, `o_dmem_we` 1; SH at 0x202 → `be` 4'b1100.
- `BUS_TIMEOUT` = 4, no ack → req high exactly 4 cycles, then `o_lsu_done` and `o_lsu_err` = 1, load rdata 0. Separately, ack and err in the same cycle → `o_lsu_err` = 1.
- LW at 0x102 with `LSU_MISALIGN_TRAP_EN` → no req, done and misalign in cycle 1. Without the macro → `o_dmem_addr` 0x100 and a normal load.
- `i_rstn` low while req high and waiting → req drops without a clock edge; after release, ready = 1 and no done pulse appears.
